// File: rtl/fractal_sync_rf_arbiter.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : fractal_sync_rf_arbiter
// Description : Shares the N_PORTS check ports of a 1D remote synchronization
//               register file among N_REQ requesters. Up to N_PORTS requests
//               are granted per cycle in round-robin order. The RF verdict is
//               registered per requester and returned on a valid/ready
//               response channel. A RUN/DRAIN/HALTED FSM quiesces RF traffic.
//               Optional statistics counters: FRACTAL_SYNC_RF_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fractal_sync_rf_arbiter #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned N_PORTS     = 2,
  parameter int unsigned LEVEL_WIDTH = 1,
  parameter int unsigned ID_WIDTH    = 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  // requester side
  input  logic [N_REQ-1:0]                     req_valid_i,
  output logic [N_REQ-1:0]                     req_ready_o,
  input  logic [N_REQ-1:0][LEVEL_WIDTH-1:0]    req_level_i,
  input  logic [N_REQ-1:0][ID_WIDTH-1:0]       req_id_i,
  output logic [N_REQ-1:0]                     rsp_valid_o,
  input  logic [N_REQ-1:0]                     rsp_ready_i,
  output logic [N_REQ-1:0][1:0]                rsp_type_o,
  // register file side
  output logic [N_PORTS-1:0][LEVEL_WIDTH-1:0]  rf_level_o,
  output logic [N_PORTS-1:0][ID_WIDTH-1:0]     rf_id_o,
  output logic [N_PORTS-1:0]                   rf_check_o,
  input  logic [N_PORTS-1:0]                   rf_present_i,
  input  logic [N_PORTS-1:0]                   rf_sig_err_i,
  input  logic [N_PORTS-1:0]                   rf_bypass_i,
  input  logic [N_PORTS-1:0]                   rf_ignore_i,
  // quiesce control
  input  logic                                 halt_i,
  output logic                                 halted_o,
  // statistics
  input  logic                                 stat_clr_i,
  output logic [31:0]                          stat_grants_o,
  output logic [31:0]                          stat_errors_o
);

  localparam int unsigned C_PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned C_CNT_W = $clog2(N_PORTS + 1);

  localparam logic [1:0] C_RSP_WAIT   = 2'd0;
  localparam logic [1:0] C_RSP_SYNC   = 2'd1;
  localparam logic [1:0] C_RSP_MERGED = 2'd2;
  localparam logic [1:0] C_RSP_ERROR  = 2'd3;

  localparam logic [1:0] C_ST_RUN    = 2'd0;
  localparam logic [1:0] C_ST_DRAIN  = 2'd1;
  localparam logic [1:0] C_ST_HALTED = 2'd2;

  // A configuration with fewer requesters than ports cannot fill the ports.
  generate
    if (N_REQ < N_PORTS) begin : g_cfg_check
      $fatal(1, "fractal_sync_rf_arbiter: N_REQ must be >= N_PORTS");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [C_PTR_W-1:0]                r_ptr;
  logic [1:0]                        r_state;
  logic [N_REQ-1:0]                  r_rsp_valid;
  logic [N_REQ-1:0][1:0]             r_rsp_type;

  // --------------------------------------------------------------------------
  // Combinational grant datapath
  // --------------------------------------------------------------------------
  logic                              w_grant_en;
  logic [N_REQ-1:0]                  w_eligible;
  logic [N_PORTS-1:0][1:0]           w_port_type;
  logic [N_REQ-1:0]                  w_grant;
  logic [N_REQ-1:0][1:0]             w_req_type;
  logic [N_PORTS-1:0]                w_port_vld;
  logic [N_PORTS-1:0][C_PTR_W-1:0]   w_port_sel;
  logic [C_PTR_W-1:0]                w_last;
  logic [C_CNT_W-1:0]                w_cnt;
  logic [C_PTR_W:0]                  w_sum;
  logic [C_PTR_W-1:0]                w_idx;
  logic [C_PTR_W-1:0]                w_ptr_nxt;
  logic [1:0]                        w_state_nxt;

  // Grants only flow in RUN, and a fresh halt request blocks them at once.
  assign w_grant_en = (r_state == C_ST_RUN) && !halt_i;

  // A requester may be served only if its response slot frees up this cycle.
  assign w_eligible = req_valid_i & (~r_rsp_valid | rsp_ready_i) & {N_REQ{w_grant_en}};

  // Classify each port's RF verdict; error dominates, then merge, then sync.
  always_comb begin
    w_port_type = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (rf_sig_err_i[k]) begin
        w_port_type[k] = C_RSP_ERROR;
      end else if (rf_bypass_i[k] || rf_ignore_i[k]) begin
        w_port_type[k] = C_RSP_MERGED;
      end else if (rf_present_i[k]) begin
        w_port_type[k] = C_RSP_SYNC;
      end else begin
        w_port_type[k] = C_RSP_WAIT;
      end
    end
  end

  // Round-robin scan from the pointer; the k-th eligible requester takes port k.
  always_comb begin
    w_grant    = '0;
    w_req_type = '0;
    w_port_vld = '0;
    w_port_sel = '0;
    w_last     = '0;
    w_cnt      = '0;
    w_sum      = '0;
    w_idx      = '0;
    for (int off = 0; off < N_REQ; off++) begin
      w_sum = {1'b0, r_ptr} + (C_PTR_W + 1)'(off);
      if (w_sum >= (C_PTR_W + 1)'(N_REQ)) begin
        w_sum = w_sum - (C_PTR_W + 1)'(N_REQ);
      end
      w_idx = w_sum[C_PTR_W-1:0];
      if (w_eligible[w_idx] && (w_cnt < C_CNT_W'(N_PORTS))) begin
        w_grant[w_idx] = 1'b1;
        w_last         = w_idx;
        for (int k = 0; k < N_PORTS; k++) begin
          if (w_cnt == C_CNT_W'(k)) begin
            w_port_vld[k]     = 1'b1;
            w_port_sel[k]     = w_idx;
            w_req_type[w_idx] = w_port_type[k];
          end
        end
        w_cnt = w_cnt + C_CNT_W'(1);
      end
    end
  end

  // Drive the RF ports; idle ports present all-zero fields.
  always_comb begin
    rf_check_o = '0;
    rf_level_o = '0;
    rf_id_o    = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (w_port_vld[k]) begin
        rf_check_o[k] = 1'b1;
        rf_level_o[k] = req_level_i[w_port_sel[k]];
        rf_id_o[k]    = req_id_i[w_port_sel[k]];
      end
    end
  end

  assign req_ready_o = w_grant;

  // Next pointer: one past the last requester served, wrapping at N_REQ.
  always_comb begin
    if (w_last == C_PTR_W'(N_REQ - 1)) begin
      w_ptr_nxt = '0;
    end else begin
      w_ptr_nxt = w_last + C_PTR_W'(1);
    end
  end

  // Pointer advances only in cycles that issued at least one grant.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr <= '0;
    end else if (|w_grant) begin
      r_ptr <= w_ptr_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Response registers
  // --------------------------------------------------------------------------
  // Load the verdict after a grant; a new grant overrides a retiring response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rsp_valid <= '0;
      r_rsp_type  <= '0;
    end else begin
      for (int r = 0; r < N_REQ; r++) begin
        if (w_grant[r]) begin
          r_rsp_valid[r] <= 1'b1;
          r_rsp_type[r]  <= w_req_type[r];
        end else if (rsp_ready_i[r]) begin
          r_rsp_valid[r] <= 1'b0;
        end
      end
    end
  end

  assign rsp_valid_o = r_rsp_valid;
  assign rsp_type_o  = r_rsp_type;

  // --------------------------------------------------------------------------
  // Halt / drain FSM
  // --------------------------------------------------------------------------
  // DRAIN completes on the edge that retires the last outstanding response,
  // since no new grants can be issued while draining.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      C_ST_RUN: begin
        if (halt_i) begin
          w_state_nxt = C_ST_DRAIN;
        end
      end
      C_ST_DRAIN: begin
        if (!halt_i) begin
          w_state_nxt = C_ST_RUN;
        end else if ((r_rsp_valid & ~rsp_ready_i) == '0) begin
          w_state_nxt = C_ST_HALTED;
        end
      end
      C_ST_HALTED: begin
        if (!halt_i) begin
          w_state_nxt = C_ST_RUN;
        end
      end
      default: w_state_nxt = C_ST_RUN;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= C_ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign halted_o = (r_state == C_ST_HALTED);

  // --------------------------------------------------------------------------
  // Statistics
  // --------------------------------------------------------------------------
`ifdef FRACTAL_SYNC_RF_ARB_STATS_EN
  logic [31:0]        r_stat_grants;
  logic [31:0]        r_stat_errors;
  logic [C_CNT_W-1:0] w_n_errors;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [C_CNT_W-1:0] b);
    logic [32:0] s;
    s = {1'b0, a} + 33'(b);
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  // Count ports that returned an ERROR verdict for a granted request.
  always_comb begin
    w_n_errors = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (w_port_vld[k] && (w_port_type[k] == C_RSP_ERROR)) begin
        w_n_errors = w_n_errors + C_CNT_W'(1);
      end
    end
  end

  // Saturating counters; clear wins over the same-cycle increment.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stat_grants <= '0;
      r_stat_errors <= '0;
    end else if (stat_clr_i) begin
      r_stat_grants <= '0;
      r_stat_errors <= '0;
    end else begin
      r_stat_grants <= sat_add(r_stat_grants, w_cnt);
      r_stat_errors <= sat_add(r_stat_errors, w_n_errors);
    end
  end

  assign stat_grants_o = r_stat_grants;
  assign stat_errors_o = r_stat_errors;
`else
  logic w_unused_stat_clr;

  assign w_unused_stat_clr = stat_clr_i;
  assign stat_grants_o     = '0;
  assign stat_errors_o     = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fractal_sync_rf_arbiter.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : tb_fractal_sync_rf_arbiter
// Description : Scoreboard bench for fractal_sync_rf_arbiter. Directed
//               stimulus pushes expected response types when a grant is
//               issued; a negedge monitor pops them on each response
//               handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fractal_sync_rf_arbiter;

  localparam int N_REQ   = 4;
  localparam int N_PORTS = 2;

  localparam logic [1:0] C_WAIT   = 2'd0;
  localparam logic [1:0] C_SYNC   = 2'd1;
  localparam logic [1:0] C_MERGED = 2'd2;
  localparam logic [1:0] C_ERROR  = 2'd3;

  logic                        clk_i;
  logic                        rst_i;
  logic [N_REQ-1:0]            req_valid_i;
  logic [N_REQ-1:0]            req_ready_o;
  logic [N_REQ-1:0][0:0]       req_level_i;
  logic [N_REQ-1:0][0:0]       req_id_i;
  logic [N_REQ-1:0]            rsp_valid_o;
  logic [N_REQ-1:0]            rsp_ready_i;
  logic [N_REQ-1:0][1:0]       rsp_type_o;
  logic [N_PORTS-1:0][0:0]     rf_level_o;
  logic [N_PORTS-1:0][0:0]     rf_id_o;
  logic [N_PORTS-1:0]          rf_check_o;
  logic [N_PORTS-1:0]          rf_present_i;
  logic [N_PORTS-1:0]          rf_sig_err_i;
  logic [N_PORTS-1:0]          rf_bypass_i;
  logic [N_PORTS-1:0]          rf_ignore_i;
  logic                        halt_i;
  logic                        halted_o;
  logic                        stat_clr_i;
  logic [31:0]                 stat_grants_o;
  logic [31:0]                 stat_errors_o;

  typedef struct packed {
    logic [7:0] req;
    logic [1:0] t;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  fractal_sync_rf_arbiter #(
    .N_REQ      (N_REQ),
    .N_PORTS    (N_PORTS),
    .LEVEL_WIDTH(1),
    .ID_WIDTH   (1)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_level_i  (req_level_i),
    .req_id_i     (req_id_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_type_o   (rsp_type_o),
    .rf_level_o   (rf_level_o),
    .rf_id_o      (rf_id_o),
    .rf_check_o   (rf_check_o),
    .rf_present_i (rf_present_i),
    .rf_sig_err_i (rf_sig_err_i),
    .rf_bypass_i  (rf_bypass_i),
    .rf_ignore_i  (rf_ignore_i),
    .halt_i       (halt_i),
    .halted_o     (halted_o),
    .stat_clr_i   (stat_clr_i),
    .stat_grants_o(stat_grants_o),
    .stat_errors_o(stat_errors_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int r, input logic [1:0] t);
    exp_t e;
    e.req = 8'(r);
    e.t   = t;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Response monitor: every handshake must match a queued expectation.
  always @(negedge clk_i) begin : mon
    int found;
    if (!rst_i) begin
      for (int r = 0; r < N_REQ; r++) begin
        if (rsp_valid_o[r] && rsp_ready_i[r]) begin
          found = -1;
          for (int i = 0; i < exp_q.size(); i++) begin
            if (found < 0 && exp_q[i].req == 8'(r)) found = i;
          end
          if (found < 0) begin
            checks++;
            failures++;
            $display("FAIL rsp_unexpected r%0d actual_type=%0d required=none", r, rsp_type_o[r]);
          end else begin
            chk($sformatf("rsp_type_r%0d", r), 32'(rsp_type_o[r]), 32'(exp_q[found].t));
            exp_q.delete(found);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i        = 1'b1;
    req_valid_i  = '0;
    rsp_ready_i  = 4'hF;
    rf_present_i = '0;
    rf_sig_err_i = '0;
    rf_bypass_i  = '0;
    rf_ignore_i  = '0;
    halt_i       = 1'b0;
    stat_clr_i   = 1'b0;
    for (int r = 0; r < N_REQ; r++) begin
      req_id_i[r]    = 1'(r % 2);
      req_level_i[r] = 1'(r / 2);
    end
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    #1;
    // Reset state
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'h0);
    chk("rst_rsp_type",  32'(rsp_type_o),  32'h0);
    chk("rst_halted",    32'(halted_o),    32'h0);
    chk("rst_req_ready", 32'(req_ready_o), 32'h0);
    chk("rst_rf_check",  32'(rf_check_o),  32'h0);
    chk("rst_stat_grants", stat_grants_o, 32'h0);

    // All four request, RF answers WAIT: r0,r1 then r2,r3 then wrap to r0,r1
    step(); req_valid_i = 4'hF; #1;
    chk("t1_c0_ready", 32'(req_ready_o), 32'b0011);
    chk("t1_c0_check", 32'(rf_check_o),  32'b11);
    chk("t1_c0_id",    32'(rf_id_o),     32'b10);
    chk("t1_c0_level", 32'(rf_level_o),  32'b00);
    push(0, C_WAIT); push(1, C_WAIT);
    step(); #1;
    chk("t1_c1_ready", 32'(req_ready_o), 32'b1100);
    chk("t1_c1_id",    32'(rf_id_o),     32'b10);
    chk("t1_c1_level", 32'(rf_level_o),  32'b11);
    push(2, C_WAIT); push(3, C_WAIT);
    step(); #1;
    chk("t1_c2_wrap_ready", 32'(req_ready_o), 32'b0011);
    push(0, C_WAIT); push(1, C_WAIT);
    step(); req_valid_i = '0; #1;
    chk("t1_idle_ready", 32'(req_ready_o), 32'h0);
    step(); step(); #1;
    chk("t1_drained", 32'(rsp_valid_o), 32'h0);

    // r0 id=1 level=0, RF present: SYNC held while rsp_ready low
    req_id_i[0]    = 1'b1;
    rsp_ready_i[0] = 1'b0;
    req_valid_i    = 4'b0001;
    rf_present_i   = 2'b01;
    #1;
    chk("t2_ready", 32'(req_ready_o), 32'b0001);
    chk("t2_check", 32'(rf_check_o),  32'b01);
    chk("t2_id",    32'(rf_id_o),     32'b01);
    chk("t2_level", 32'(rf_level_o),  32'b00);
    push(0, C_SYNC);
    step(); rf_present_i = '0; #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t2_hold%0d_valid", i), 32'(rsp_valid_o[0]), 32'h1);
      chk($sformatf("t2_hold%0d_type", i),  32'(rsp_type_o[0]),  32'(C_SYNC));
      chk($sformatf("t2_hold%0d_nogrant", i), 32'(req_ready_o), 32'h0);
      step(); #1;
    end
    rsp_ready_i[0] = 1'b1; #1;
    chk("t2_b2b_ready", 32'(req_ready_o), 32'b0001);
    push(0, C_WAIT);
    step(); req_valid_i = '0; #1;
    chk("t2_b2b_valid", 32'(rsp_valid_o[0]), 32'h1);
    chk("t2_b2b_type",  32'(rsp_type_o[0]),  32'(C_WAIT));
    step(); step(); #1;
    chk("t2_drained", 32'(rsp_valid_o), 32'h0);
    req_id_i[0] = 1'b0;

    // r1,r2 together: bypass on port 0, ignore on port 1 -> both MERGED
    req_valid_i = 4'b0110;
    rf_bypass_i = 2'b01;
    rf_ignore_i = 2'b10;
    #1;
    chk("t3_ready", 32'(req_ready_o), 32'b0110);
    chk("t3_id",    32'(rf_id_o),     32'b01);
    chk("t3_level", 32'(rf_level_o),  32'b10);
    push(1, C_MERGED); push(2, C_MERGED);
    step(); req_valid_i = '0; rf_bypass_i = '0; rf_ignore_i = '0; stat_clr_i = 1'b1;
    step(); stat_clr_i = 1'b0;

    // r3 with sig_err and present on port 0 -> ERROR
    req_valid_i  = 4'b1000;
    rf_sig_err_i = 2'b01;
    rf_present_i = 2'b01;
    #1;
    chk("t4_ready", 32'(req_ready_o), 32'b1000);
    chk("t4_id",    32'(rf_id_o),     32'b01);
    chk("t4_level", 32'(rf_level_o),  32'b01);
    push(3, C_ERROR);
    step(); req_valid_i = '0; rf_sig_err_i = '0; rf_present_i = '0; #1;
`ifdef FRACTAL_SYNC_RF_ARB_STATS_EN
    chk("t4_stat_errors", stat_errors_o, 32'd1);
    chk("t4_stat_grants", stat_grants_o, 32'd1);
`else
    chk("t4_stat_errors", stat_errors_o, 32'd0);
    chk("t4_stat_grants", stat_grants_o, 32'd0);
`endif
    step(); step();

    // Halt with two responses pending
    rsp_ready_i = 4'b1100;
    req_valid_i = 4'b0011;
    #1;
    chk("t5_pre_ready", 32'(req_ready_o), 32'b0011);
    push(0, C_WAIT); push(1, C_WAIT);
    step(); halt_i = 1'b1; req_valid_i = 4'hF; #1;
    chk("t5_halt_block", 32'(req_ready_o), 32'h0);
    chk("t5_halt_notyet", 32'(halted_o), 32'h0);
    step(); #1;
    chk("t5_drain_block", 32'(req_ready_o), 32'h0);
    chk("t5_drain_halted", 32'(halted_o), 32'h0);
    rsp_ready_i[0] = 1'b1;
    step(); #1;
    chk("t5_one_pending", 32'(halted_o), 32'h0);
    rsp_ready_i[1] = 1'b1;
    step(); #1;
    chk("t5_halted", 32'(halted_o), 32'h1);
    chk("t5_halted_block", 32'(req_ready_o), 32'h0);
    halt_i = 1'b0; rsp_ready_i = 4'b0111; #1;
    chk("t5_release_same_cycle", 32'(req_ready_o), 32'h0);
    step(); #1;
    chk("t5_resume_halted", 32'(halted_o), 32'h0);
    chk("t5_resume_ready", 32'(req_ready_o), 32'b1100);
    push(2, C_WAIT); push(3, C_WAIT);

    // Async reset while r3 response is pending and FSM is draining
    step(); req_valid_i = '0; halt_i = 1'b1; #1;
    chk("t6_r3_pending", 32'(rsp_valid_o[3]), 32'h1);
    step();
    rst_i = 1'b1; #1;
    chk("t6_rst_valid", 32'(rsp_valid_o), 32'h0);
    chk("t6_rst_halted", 32'(halted_o), 32'h0);
    exp_q.delete();
    rst_i = 1'b0; halt_i = 1'b0; rsp_ready_i = 4'hF;
    step(); req_valid_i = 4'hF; #1;
    chk("t6_post_rst_ready", 32'(req_ready_o), 32'b0011);
    push(0, C_WAIT); push(1, C_WAIT);
    step(); req_valid_i = '0;
    step(); step(); #1;
    chk("t6_drained", 32'(rsp_valid_o), 32'h0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
